// File: rtl/mem_arbiter.sv
// N-port round-robin arbiter in front of one single-port synchronous memory.
// Optional bus locking for atomic read-modify-write is compiled in with `define ARB_LOCK_EN.
module mem_arbiter #(
   parameter int NPORTS   = 2,
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 4
) (
   input  logic                       i_Clk,
   input  logic                       i_Rstn,
   input  logic [NPORTS-1:0]          i_Req,
   input  logic [NPORTS-1:0]          i_We,
   input  logic [NPORTS*ADDR_W-1:0]   i_Addr,
   input  logic [NPORTS*DATA_W-1:0]   i_WData,
   input  logic [NPORTS*DATA_W/8-1:0] i_Be,
   input  logic [NPORTS-1:0]          i_Lock,
   output logic [NPORTS-1:0]          o_Gnt,
   output logic [NPORTS-1:0]          o_Stall,
   output logic [NPORTS-1:0]          o_RValid,
   output logic [DATA_W-1:0]          o_RData,
   output logic                       o_Mem_En,
   output logic                       o_Mem_We,
   output logic [DATA_W/8-1:0]        o_Mem_Be,
   output logic [ADDR_W-1:0]          o_Mem_Addr,
   output logic [DATA_W-1:0]          o_Mem_WData,
   input  logic [DATA_W-1:0]          i_Mem_RData
);

   localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int BW = DATA_W / 8;

   logic [PW-1:0]     ptr_q, ptr_d;
   logic [NPORTS-1:0] elig;
   logic [NPORTS-1:0] gnt;
   logic              gnt_any;
   logic [PW-1:0]     gnt_idx;
   int unsigned       idx;

`ifdef ARB_LOCK_EN
   // state    | meaning
   // UNLOCKED | plain round-robin among all requesters
   // LOCKED   | only owner_q may be granted; cnt_q grants taken so far
   localparam int CW = $clog2(LOCK_MAX + 1);

   typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

   lock_state_e   state_q;
   logic [PW-1:0] owner_q;
   logic [CW-1:0] cnt_q;
   logic          lock_hold;

   // The lock only constrains arbitration while the owner keeps both Req and Lock up.
   assign lock_hold = (state_q == LOCKED) && i_Req[owner_q] && i_Lock[owner_q];
   assign elig      = lock_hold ? (i_Req & (NPORTS'(1) << owner_q)) : i_Req;

   always_ff @(posedge i_Clk or negedge i_Rstn) begin
      if (!i_Rstn) begin
         state_q <= UNLOCKED;
         owner_q <= '0;
         cnt_q   <= '0;
      end else if (lock_hold) begin
         if (int'(cnt_q) >= LOCK_MAX - 1) begin
            state_q <= UNLOCKED;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else if (gnt_any && i_Lock[gnt_idx] && (LOCK_MAX > 1)) begin
         state_q <= LOCKED;
         owner_q <= gnt_idx;
         cnt_q   <= CW'(1);
      end else begin
         state_q <= UNLOCKED;
         cnt_q   <= '0;
      end
   end
`else
   logic unused_lock;

   assign unused_lock = ^i_Lock;
   assign elig        = i_Req;
`endif

   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int i = 0; i < NPORTS; i++) begin
         idx = (int'(ptr_q) + i) % NPORTS;
         if (!gnt_any && elig[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = PW'(idx);
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   // Pointer moves past the winner, so a lock exit naturally leaves P at owner+1.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         if (int'(gnt_idx) == NPORTS - 1) ptr_d = '0;
         else                             ptr_d = gnt_idx + 1'b1;
      end
   end

   assign o_Gnt   = gnt & {NPORTS{i_Rstn}};
   assign o_Stall = i_Req & ~o_Gnt;

   logic          t1_v_q, t2_v_q;
   logic [PW-1:0] t1_idx_q, t2_idx_q;

   always_ff @(posedge i_Clk or negedge i_Rstn) begin
      if (!i_Rstn) begin
         ptr_q       <= '0;
         o_Mem_En    <= 1'b0;
         o_Mem_We    <= 1'b0;
         o_Mem_Be    <= '0;
         o_Mem_Addr  <= '0;
         o_Mem_WData <= '0;
         t1_v_q      <= 1'b0;
         t1_idx_q    <= '0;
         t2_v_q      <= 1'b0;
         t2_idx_q    <= '0;
      end else begin
         ptr_q    <= ptr_d;
         o_Mem_En <= gnt_any;
         if (gnt_any) begin
            o_Mem_We   <= i_We[gnt_idx];
            o_Mem_Addr <= i_Addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            if (i_We[gnt_idx]) begin
               o_Mem_Be    <= i_Be[int'(gnt_idx)*BW +: BW];
               o_Mem_WData <= i_WData[int'(gnt_idx)*DATA_W +: DATA_W];
            end else begin
               o_Mem_Be    <= '1;
               o_Mem_WData <= '0;
            end
         end
         t1_v_q   <= gnt_any && !i_We[gnt_idx];
         t1_idx_q <= gnt_idx;
         t2_v_q   <= t1_v_q;
         t2_idx_q <= t1_idx_q;
      end
   end

   always_comb begin
      o_RValid = '0;
      if (t2_v_q) o_RValid[t2_idx_q] = 1'b1;
   end

   assign o_RData = t2_v_q ? i_Mem_RData : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (NPORTS=2); lock expectations follow ARB_LOCK_EN.
module tb_mem_arbiter;
   localparam int NP = 2;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NP-1:0]    req = '0, we = '0, lock = '0;
   logic [AW-1:0]    addr [NP];
   logic [DW-1:0]    wdata [NP];
   logic [BW-1:0]    be [NP];
   logic [NP*AW-1:0] addr_p;
   logic [NP*DW-1:0] wdata_p;
   logic [NP*BW-1:0] be_p;

   always_comb begin
      addr_p  = '0;
      wdata_p = '0;
      be_p    = '0;
      for (int k = 0; k < NP; k++) begin
         addr_p[k*AW +: AW]  = addr[k];
         wdata_p[k*DW +: DW] = wdata[k];
         be_p[k*BW +: BW]    = be[k];
      end
   end

   logic [NP-1:0] o_gnt, o_stall, o_rvalid;
   logic [DW-1:0] o_rdata, mem_wdata, mem_rdata;
   logic          mem_en, mem_we;
   logic [BW-1:0] mem_be;
   logic [AW-1:0] mem_addr;

   mem_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(4)) dut (
      .i_Clk(clk), .i_Rstn(rst_n), .i_Req(req), .i_We(we), .i_Addr(addr_p),
      .i_WData(wdata_p), .i_Be(be_p), .i_Lock(lock), .o_Gnt(o_gnt), .o_Stall(o_stall),
      .o_RValid(o_rvalid), .o_RData(o_rdata), .o_Mem_En(mem_en), .o_Mem_We(mem_we),
      .o_Mem_Be(mem_be), .o_Mem_Addr(mem_addr), .o_Mem_WData(mem_wdata),
      .i_Mem_RData(mem_rdata)
   );

   // Memory model: untouched words read as C0DE_0000 | addr, except 0x010.
   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return (a == 10'h010) ? 32'hDEADBEEF : {16'hC0DE, 6'b0, a};
   endfunction

   logic [DW-1:0]   wmem [1024];
   logic [1023:0]   wr_valid = '0;
   logic [DW-1:0]   cur;

   always @(posedge clk) begin
      if (mem_en) begin
         cur = wr_valid[mem_addr] ? wmem[mem_addr] : dflt(mem_addr);
         if (mem_we) begin
            for (int b = 0; b < BW; b++)
               if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
            wmem[mem_addr]     <= cur;
            wr_valid[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= cur;
         end
      end
   end

   typedef struct packed {
      logic          we;
      logic [BW-1:0] be;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic [NP-1:0] port;
      logic [DW-1:0] data;
   } rd_t;

   cmd_t          cmd_q [$];
   rd_t           rd_q [$];
   cmd_t          mc;
   rd_t           mr;
   logic [DW-1:0] exp_rd [NP];
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, check grant/stall, and queue the expected memory command and read return.
   task automatic cyc(input logic [NP-1:0] r, input logic [NP-1:0] w, input logic [NP-1:0] l,
                      input logic [NP-1:0] exp_gnt, input bit push);
      cmd_t c;
      rd_t  d;
      req  = r;
      we   = w;
      lock = l;
      @(negedge clk);
      check("gnt", 64'(o_gnt), 64'(exp_gnt));
      check("stall", 64'(o_stall), 64'(r & ~exp_gnt));
      if (push) begin
         for (int k = 0; k < NP; k++) begin
            if (exp_gnt[k]) begin
               c.we    = w[k];
               c.be    = w[k] ? be[k] : '1;
               c.addr  = addr[k];
               c.wdata = w[k] ? wdata[k] : '0;
               cmd_q.push_back(c);
               if (!w[k]) begin
                  d.port = NP'(1) << k;
                  d.data = exp_rd[k];
                  rd_q.push_back(d);
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_en) begin
            if (cmd_q.size() == 0) begin
               check("cmd_unexpected", 64'(mem_en), 64'(0));
            end else begin
               mc = cmd_q.pop_front();
               check("mem_we", 64'(mem_we), 64'(mc.we));
               check("mem_be", 64'(mem_be), 64'(mc.be));
               check("mem_addr", 64'(mem_addr), 64'(mc.addr));
               check("mem_wdata", 64'(mem_wdata), 64'(mc.wdata));
            end
         end
         if (o_rvalid != '0) begin
            if (rd_q.size() == 0) begin
               check("rvalid_unexpected", 64'(o_rvalid), 64'(0));
            end else begin
               mr = rd_q.pop_front();
               check("rvalid_port", 64'(o_rvalid), 64'(mr.port));
               check("rdata", 64'(o_rdata), 64'(mr.data));
            end
         end
      end
   end

   logic [NP-1:0] lock_exp [5];

   initial begin
      for (int k = 0; k < NP; k++) begin
         addr[k]   = '0;
         wdata[k]  = 32'hFFFF0000;
         be[k]     = 4'h3;
         exp_rd[k] = '0;
      end
`ifdef ARB_LOCK_EN
      lock_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
`else
      lock_exp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif

      // Reset held with all ports requesting
      req = '1;
      @(negedge clk);
      check("rst_gnt", 64'(o_gnt), 64'(0));
      check("rst_mem_en", 64'(mem_en), 64'(0));
      check("rst_rvalid", 64'(o_rvalid), 64'(0));
      check("rst_rdata", 64'(o_rdata), 64'(0));
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;

      addr[0] = 10'h004; exp_rd[0] = 32'hC0DE0004;
      addr[1] = 10'h008; exp_rd[1] = 32'hC0DE0008;
      cyc(2'b11, 2'b00, 2'b00, 2'b01, 1);
      cyc(2'b10, 2'b00, 2'b00, 2'b10, 1);
      repeat (3) cyc(2'b00, 2'b00, 2'b00, 2'b00, 1);

      // Single read with explicit latency checks
      addr[1] = 10'h010; exp_rd[1] = 32'hDEADBEEF;
      cyc(2'b10, 2'b00, 2'b00, 2'b10, 1);
      req = '0;
      @(negedge clk);
      check("sr_mem_en", 64'(mem_en), 64'(1));
      check("sr_mem_addr", 64'(mem_addr), 64'(10'h010));
      check("sr_rvalid_early", 64'(o_rvalid), 64'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("sr_rvalid", 64'(o_rvalid), 64'(2'b10));
      check("sr_rdata", 64'(o_rdata), 64'(32'hDEADBEEF));
      @(posedge clk);
      #1;

      // Contention: continuous reads from both ports
      addr[0] = 10'h030; exp_rd[0] = 32'hC0DE0030;
      addr[1] = 10'h031; exp_rd[1] = 32'hC0DE0031;
      for (int i = 0; i < 6; i++)
         cyc(2'b11, 2'b00, 2'b00, (i % 2 == 0) ? 2'b01 : 2'b10, 1);
      repeat (3) cyc(2'b00, 2'b00, 2'b00, 2'b00, 1);

      // Byte-enabled write, then read back the merged word
      addr[0] = 10'h020; wdata[0] = 32'h11223344; be[0] = 4'b0101;
      cyc(2'b01, 2'b01, 2'b00, 2'b01, 1);
      wdata[0] = 32'hFFFF0000;
      addr[1] = 10'h020; exp_rd[1] = 32'hC0220044;
      cyc(2'b10, 2'b00, 2'b00, 2'b10, 1);
      repeat (3) cyc(2'b00, 2'b00, 2'b00, 2'b00, 1);

      // Port 1 locks while port 0 competes
      addr[0] = 10'h041; exp_rd[0] = 32'hC0DE0041;
      addr[1] = 10'h040; exp_rd[1] = 32'hC0DE0040;
      cyc(2'b01, 2'b00, 2'b00, 2'b01, 1);
      for (int i = 0; i < 5; i++)
         cyc(2'b11, 2'b00, 2'b10, lock_exp[i], 1);
      repeat (3) cyc(2'b00, 2'b00, 2'b00, 2'b00, 1);

      // Reset during an in-flight read
      addr[0] = 10'h050; exp_rd[0] = 32'hC0DE0050;
      cyc(2'b01, 2'b00, 2'b00, 2'b01, 0);
      rst_n = 1'b0;
      req   = '0;
      repeat (2) begin
         @(negedge clk);
         check("mid_rst_mem_en", 64'(mem_en), 64'(0));
         check("mid_rst_rvalid", 64'(o_rvalid), 64'(0));
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_rvalid", 64'(o_rvalid), 64'(0));
      end
      @(posedge clk);
      #1;
      addr[1] = 10'h060; exp_rd[1] = 32'hC0DE0060;
      cyc(2'b11, 2'b00, 2'b00, 2'b01, 1);
      cyc(2'b10, 2'b00, 2'b00, 2'b10, 1);
      repeat (4) cyc(2'b00, 2'b00, 2'b00, 2'b00, 1);

      check("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
      check("rd_q_drained", 64'(rd_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
